// File: rtl/game_sequencer.sv
// Frame-level Tetris controller: once per vsync tick it chooses a move, applies
// gravity, and sequences line-clear/spawn operations on the tetrimino engine.
module game_sequencer #(
    parameter int GRAVITY_INIT    = 48,
    parameter int GRAVITY_STEP    = 3,
    parameter int GRAVITY_MIN     = 3,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] actions,
    input  logic       vsync,
    output logic       op_valid,
    output logic [2:0] op_code,
    input  logic       op_ready,
    input  logic       op_done,
    input  logic       res_landed,
    input  logic [2:0] res_lines,
    input  logic       res_topout,
    output logic [7:0] score,
    output logic [7:0] lines,
    output logic [3:0] level,
    output logic       game_over,
    output logic       frame_commit,
    output logic [7:0] overrun
);

    typedef enum logic [3:0] {
        IDLE, MOVE_REQ, MOVE_WAIT, GRAV_REQ, GRAV_WAIT, CLEAR_REQ, CLEAR_WAIT,
        SPAWN_REQ, SPAWN_WAIT, COMMIT, OVER
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RIGHT  = 3'd1;
    localparam logic [2:0] OP_LEFT   = 3'd2;
    localparam logic [2:0] OP_ROTATE = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_HARD   = 3'd5;
    localparam logic [2:0] OP_SPAWN  = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    state_t state, state_next;

    logic              vsync_q, tick;
    logic [4:0]        act_q, act_prev, act_new;
    logic              pending, spawn_first, grav_due;
    logic [2:0]        move_op, move_sel;
    logic [7:0]        gcount;
    logic signed [5:0] lines_to_next, ltn_dec;
    int                period;
    logic              due_now, frame_go, restart, op_req, done_evt;
    logic [2:0]        n_clr;
    logic [3:0]        pts;
    logic [8:0]        lines_sum, score_sum;

    assign act_new  = act_q & ~act_prev;
    assign frame_go = (state == IDLE) && (tick || pending);
    assign restart  = (state == OVER) && tick && act_new[4];
    assign op_req   = state inside {MOVE_REQ, GRAV_REQ, CLEAR_REQ, SPAWN_REQ};
    // Done counts in WAIT, or in REQ when it coincides with acceptance.
    assign done_evt = op_done && ((op_req && op_ready) ||
                      (state inside {MOVE_WAIT, GRAV_WAIT, CLEAR_WAIT, SPAWN_WAIT}));

    always_comb begin
        move_sel = OP_NOP;
        if (act_new[4])                     move_sel = OP_HARD;
        else if (act_new[2])                move_sel = OP_ROTATE;
        else if (act_new[1] && !act_new[0]) move_sel = OP_LEFT;
        else if (act_new[0] && !act_new[1]) move_sel = OP_RIGHT;
    end

    always_comb begin
        period = GRAVITY_INIT - int'(level) * GRAVITY_STEP;
        if (period < GRAVITY_MIN) period = GRAVITY_MIN;
        due_now = act_q[3] || (int'(gcount) >= period - 1);
    end

    // Line-clear arithmetic; counts above four are treated as a tetris.
    always_comb begin
        n_clr = (res_lines > 3'd4) ? 3'd4 : res_lines;
        unique case (n_clr)
            3'd0:    pts = 4'd0;
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
        lines_sum = {1'b0, lines} + {6'b0, n_clr};
        score_sum = {1'b0, score} + {5'b0, pts};
        ltn_dec   = lines_to_next - $signed({3'b000, n_clr});
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (frame_go) begin
                if (spawn_first)             state_next = SPAWN_REQ;
                else if (move_sel != OP_NOP) state_next = MOVE_REQ;
                else if (due_now)            state_next = GRAV_REQ;
                else                         state_next = COMMIT;
            end
            MOVE_REQ, MOVE_WAIT: begin
                if (done_evt) begin
                    if (move_op == OP_HARD) state_next = CLEAR_REQ;
                    else if (grav_due)      state_next = GRAV_REQ;
                    else                    state_next = COMMIT;
                end else if (op_req && op_ready) state_next = MOVE_WAIT;
            end
            GRAV_REQ, GRAV_WAIT: begin
                if (done_evt)                    state_next = res_landed ? CLEAR_REQ : COMMIT;
                else if (op_req && op_ready)     state_next = GRAV_WAIT;
            end
            CLEAR_REQ, CLEAR_WAIT: begin
                if (done_evt)                    state_next = SPAWN_REQ;
                else if (op_req && op_ready)     state_next = CLEAR_WAIT;
            end
            SPAWN_REQ, SPAWN_WAIT: begin
                if (done_evt)                    state_next = res_topout ? OVER : COMMIT;
                else if (op_req && op_ready)     state_next = SPAWN_WAIT;
            end
            COMMIT:  state_next = IDLE;
            OVER:    if (restart) state_next = SPAWN_REQ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_valid     = op_req;
        frame_commit = (state == COMMIT);
        unique case (state)
            MOVE_REQ:  op_code = move_op;
            GRAV_REQ:  op_code = OP_DOWN;
            CLEAR_REQ: op_code = OP_CLEAR;
            SPAWN_REQ: op_code = OP_SPAWN;
            default:   op_code = OP_NOP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            tick          <= 1'b0;
            act_q         <= '0;
            act_prev      <= '0;
            pending       <= 1'b0;
            spawn_first   <= 1'b1;
            grav_due      <= 1'b0;
            move_op       <= OP_NOP;
            gcount        <= '0;
            lines_to_next <= 6'(LINES_PER_LEVEL);
            score         <= '0;
            lines         <= '0;
            level         <= '0;
            game_over     <= 1'b0;
            overrun       <= '0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync && !vsync_q;
            if (vsync && !vsync_q) begin
                act_q    <= actions;
                act_prev <= act_q;
            end

            // A tick landing while IDLE consumes pending stays queued.
            if (frame_go) begin
                pending <= pending && tick;
                if (spawn_first) begin
                    spawn_first <= 1'b0;
                end else begin
                    move_op  <= move_sel;
                    grav_due <= due_now;
                    gcount   <= due_now ? 8'd0 : gcount + 8'd1;
                end
            end else if (tick && state != OVER) begin
                if (!pending)               pending <= 1'b1;
                else if (overrun != 8'hFF)  overrun <= overrun + 8'd1;
            end

            if (done_evt) begin
                unique case (state)
                    MOVE_REQ, MOVE_WAIT: if (move_op == OP_HARD) gcount <= '0;
                    GRAV_REQ, GRAV_WAIT: if (res_landed) gcount <= '0;
                    CLEAR_REQ, CLEAR_WAIT: begin
                        lines <= lines_sum[8] ? 8'hFF : lines_sum[7:0];
                        score <= score_sum[8] ? 8'hFF : score_sum[7:0];
                        if (ltn_dec <= 0) begin
                            if (level != 4'hF) level <= level + 4'd1;
                            lines_to_next <= ltn_dec + 6'(LINES_PER_LEVEL);
                        end else begin
                            lines_to_next <= ltn_dec;
                        end
                    end
                    SPAWN_REQ, SPAWN_WAIT: begin
                        gcount <= '0;
                        if (res_topout) game_over <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (restart) begin
                score         <= '0;
                lines         <= '0;
                level         <= '0;
                gcount        <= '0;
                game_over     <= 1'b0;
                lines_to_next <= 6'(LINES_PER_LEVEL);
            end
        end
    end

endmodule
